// File: rtl/mem_access_pkg.sv
// mem_access_pkg
//   Shared definitions for the MEM stage: memory operation codes, exception
//   codes, the stage FSM state type and small operation-decode helpers.
//   No ports; imported by mem_align and mem_access.
package mem_access_pkg;

  // Memory operation codes as presented by the EX stage.
  localparam logic [3:0] MEM_OP_NONE = 4'd0;
  localparam logic [3:0] MEM_OP_LW   = 4'd1;
  localparam logic [3:0] MEM_OP_LH   = 4'd2;
  localparam logic [3:0] MEM_OP_LHU  = 4'd3;
  localparam logic [3:0] MEM_OP_LB   = 4'd4;
  localparam logic [3:0] MEM_OP_LBU  = 4'd5;
  localparam logic [3:0] MEM_OP_SW   = 4'd6;
  localparam logic [3:0] MEM_OP_SH   = 4'd7;
  localparam logic [3:0] MEM_OP_SB   = 4'd8;

  // Exception codes reported alongside each write-back pulse.
  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_ALIGN   = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  function automatic logic is_store(input logic [3:0] op);
    return (op == MEM_OP_SW) || (op == MEM_OP_SH) || (op == MEM_OP_SB);
  endfunction

  // Codes above SB are unused and are treated like MEM_OP_NONE.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op >= MEM_OP_LW) && (op <= MEM_OP_SB);
  endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align
//   Combinational lane logic for the MEM stage, keyed on op and addr[1:0]:
//   alignment check, byte-enable generation, store-data lane replication and
//   load lane extraction with sign/zero extension.
// Ports:
//   op_i           memory operation code
//   addr_lo_i      effective address bits [1:0]
//   store_data_i   raw store operand
//   load_data_i    raw 32-bit word returned by the data memory
//   be_o           byte enables for the access
//   store_lanes_o  store data replicated into every lane it may occupy
//   load_value_o   extracted and extended load result
//   misaligned_o   access violates its natural alignment
module mem_align
  import mem_access_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] store_lanes_o,
  output logic [31:0] load_value_o,
  output logic        misaligned_o
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Select the addressed byte and halfword out of the returned word.
  always_comb begin
    lane_byte = load_data_i[7:0];
    case (addr_lo_i)
      2'd0: lane_byte = load_data_i[7:0];
      2'd1: lane_byte = load_data_i[15:8];
      2'd2: lane_byte = load_data_i[23:16];
      2'd3: lane_byte = load_data_i[31:24];
      default: lane_byte = load_data_i[7:0];
    endcase
    lane_half = addr_lo_i[1] ? load_data_i[31:16] : load_data_i[15:0];
  end

  // Per-op enables, lane replication and extension. Loads also carry the
  // enables of the lanes they read so the bus sees a consistent request.
  always_comb begin
    be_o          = 4'b0000;
    store_lanes_o = store_data_i;
    load_value_o  = load_data_i;
    misaligned_o  = 1'b0;
    case (op_i)
      MEM_OP_LW, MEM_OP_SW: begin
        misaligned_o = (addr_lo_i != 2'b00);
        be_o         = 4'b1111;
      end
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: begin
        misaligned_o  = addr_lo_i[0];
        be_o          = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        store_lanes_o = {2{store_data_i[15:0]}};
        load_value_o  = (op_i == MEM_OP_LH) ? {{16{lane_half[15]}}, lane_half}
                                            : {16'h0000, lane_half};
      end
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: begin
        be_o          = 4'b0001 << addr_lo_i;
        store_lanes_o = {4{store_data_i[7:0]}};
        load_value_o  = (op_i == MEM_OP_LB) ? {{24{lane_byte[7]}}, lane_byte}
                                            : {24'h000000, lane_byte};
      end
      default: begin
        be_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access
//   MEM stage of the 5-stage MIPS pipeline. Takes EX results, performs
//   word/halfword/byte loads and stores over a request/grant/response data
//   bus with a timeout, and returns registered write-back data to WB.
// Parameters:
//   TIMEOUT  cycles allowed in REQ or WAIT before the access is aborted (1..1023)
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid_i / in_ready_o      EX handshake; ready only while idle
//   mem_op_i, waddr_i, wreg_i    operation, destination register, write enable
//   wdata_i, reg2_i              ALU result / effective address, store data
//   dm_req_o .. dm_wdata_o       data-memory request fields (registered)
//   dm_gnt_i, dm_rvalid_i,
//   dm_rdata_i                   data-memory grant and load response
//   wb_valid_o                   one-cycle result pulse
//   waddr_o, wreg_o, wdata_o     write-back fields, held between pulses
//   exc_o                        00 none, 01 misaligned, 10 bus timeout
//   stall_o                      upstream stall, the inverse of in_ready_o
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  mem_op_i,
  input  logic [4:0]  waddr_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] reg2_i,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [3:0]  dm_be_o,
  output logic [31:0] dm_wdata_o,
  input  logic        dm_gnt_i,
  input  logic        dm_rvalid_i,
  input  logic [31:0] dm_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  waddr_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [1:0]  exc_o,
  output logic        stall_o
);

  // The counter starts at 0 on the first cycle in REQ/WAIT, so the last
  // permitted cycle is the one where it reads TIMEOUT-1.
  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [4:0]  waddr_q, waddr_d;
  logic        wreg_q, wreg_d;

  logic        dm_req_q, dm_req_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [3:0]  dm_be_q, dm_be_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;

  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_waddr_q, wb_waddr_d;
  logic        wb_wreg_q, wb_wreg_d;
  logic [31:0] wb_wdata_q, wb_wdata_d;
  logic [1:0]  exc_q, exc_d;

  logic [3:0]  align_op;
  logic [1:0]  align_addr_lo;
  logic [3:0]  align_be;
  logic [31:0] align_store;
  logic [31:0] align_load;
  logic        align_misaligned;

  // While idle the lane logic looks at the incoming instruction; once an
  // access is in flight it looks at the latched op/address so the load
  // extract in WAIT uses the original address bits.
  always_comb begin
    align_op      = op_q;
    align_addr_lo = addr_lo_q;
    if (state_q == ST_IDLE) begin
      align_op      = mem_op_i;
      align_addr_lo = wdata_i[1:0];
    end
  end

  mem_align u_align (
    .op_i          (align_op),
    .addr_lo_i     (align_addr_lo),
    .store_data_i  (reg2_i),
    .load_data_i   (dm_rdata_i),
    .be_o          (align_be),
    .store_lanes_o (align_store),
    .load_value_o  (align_load),
    .misaligned_o  (align_misaligned)
  );

  // Next-state and next-output logic. Every write-back field holds unless a
  // result is produced; wb_valid is the only signal that defaults low.
  // Grant/rvalid are tested before the timeout so they win a same-cycle tie.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_lo_d  = addr_lo_q;
    waddr_d    = waddr_q;
    wreg_d     = wreg_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_be_d    = dm_be_q;
    dm_wdata_d = dm_wdata_q;
    wb_valid_d = 1'b0;
    wb_waddr_d = wb_waddr_q;
    wb_wreg_d  = wb_wreg_q;
    wb_wdata_d = wb_wdata_q;
    exc_d      = exc_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          if (!is_mem_op(mem_op_i)) begin
            wb_valid_d = 1'b1;
            wb_waddr_d = waddr_i;
            wb_wreg_d  = wreg_i;
            wb_wdata_d = wdata_i;
            exc_d      = EXC_NONE;
          end else if (align_misaligned) begin
            wb_valid_d = 1'b1;
            wb_waddr_d = waddr_i;
            wb_wreg_d  = 1'b0;
            wb_wdata_d = wdata_i;
            exc_d      = EXC_ALIGN;
          end else begin
            state_d    = ST_REQ;
            cnt_d      = 10'd0;
            op_d       = mem_op_i;
            addr_lo_d  = wdata_i[1:0];
            waddr_d    = waddr_i;
            wreg_d     = wreg_i;
            dm_req_d   = 1'b1;
            dm_we_d    = is_store(mem_op_i);
            dm_addr_d  = {wdata_i[31:2], 2'b00};
            dm_be_d    = align_be;
            dm_wdata_d = align_store;
          end
        end
      end

      ST_REQ: begin
        if (dm_gnt_i) begin
          dm_req_d = 1'b0;
          if (is_store(op_q)) begin
            state_d    = ST_IDLE;
            wb_valid_d = 1'b1;
            wb_waddr_d = waddr_q;
            wb_wreg_d  = 1'b0;
            exc_d      = EXC_NONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 10'd0;
          end
        end else if (cnt_q == CNT_LAST) begin
          dm_req_d   = 1'b0;
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          wb_waddr_d = waddr_q;
          wb_wreg_d  = 1'b0;
          exc_d      = EXC_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end

      ST_WAIT: begin
        if (dm_rvalid_i) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          wb_waddr_d = waddr_q;
          wb_wreg_d  = wreg_q;
          wb_wdata_d = align_load;
          exc_d      = EXC_NONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          wb_waddr_d = waddr_q;
          wb_wreg_d  = 1'b0;
          exc_d      = EXC_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        dm_req_d = 1'b0;
      end
    endcase
  end

  // All state and outputs are registered; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 10'd0;
      op_q       <= MEM_OP_NONE;
      addr_lo_q  <= 2'b00;
      waddr_q    <= 5'd0;
      wreg_q     <= 1'b0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= 32'd0;
      dm_be_q    <= 4'b0000;
      dm_wdata_q <= 32'd0;
      wb_valid_q <= 1'b0;
      wb_waddr_q <= 5'd0;
      wb_wreg_q  <= 1'b0;
      wb_wdata_q <= 32'd0;
      exc_q      <= EXC_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      addr_lo_q  <= addr_lo_d;
      waddr_q    <= waddr_d;
      wreg_q     <= wreg_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_be_q    <= dm_be_d;
      dm_wdata_q <= dm_wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_waddr_q <= wb_waddr_d;
      wb_wreg_q  <= wb_wreg_d;
      wb_wdata_q <= wb_wdata_d;
      exc_q      <= exc_d;
    end
  end

  assign in_ready_o = (state_q == ST_IDLE);
  assign stall_o    = (state_q != ST_IDLE);
  assign dm_req_o   = dm_req_q;
  assign dm_we_o    = dm_we_q;
  assign dm_addr_o  = dm_addr_q;
  assign dm_be_o    = dm_be_q;
  assign dm_wdata_o = dm_wdata_q;
  assign wb_valid_o = wb_valid_q;
  assign waddr_o    = wb_waddr_q;
  assign wreg_o     = wb_wreg_q;
  assign wdata_o    = wb_wdata_q;
  assign exc_o      = exc_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access
//   Self-checking bench for mem_access with TIMEOUT=4. Inputs change 1 ns
//   after the rising edge and outputs are sampled at the same point, well
//   away from the active edge.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [3:0]  mem_op_i;
  logic [4:0]  waddr_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [31:0] reg2_i;
  logic        dm_req_o;
  logic        dm_we_o;
  logic [31:0] dm_addr_o;
  logic [3:0]  dm_be_o;
  logic [31:0] dm_wdata_o;
  logic        dm_gnt_i;
  logic        dm_rvalid_i;
  logic [31:0] dm_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  waddr_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [1:0]  exc_o;
  logic        stall_o;

  int checks = 0;
  int errors = 0;

  mem_access #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .mem_op_i    (mem_op_i),
    .waddr_i     (waddr_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .reg2_i      (reg2_i),
    .dm_req_o    (dm_req_o),
    .dm_we_o     (dm_we_o),
    .dm_addr_o   (dm_addr_o),
    .dm_be_o     (dm_be_o),
    .dm_wdata_o  (dm_wdata_o),
    .dm_gnt_i    (dm_gnt_i),
    .dm_rvalid_i (dm_rvalid_i),
    .dm_rdata_i  (dm_rdata_i),
    .wb_valid_o  (wb_valid_o),
    .waddr_o     (waddr_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .exc_o       (exc_o),
    .stall_o     (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [31:0] rdata;
    int          gnt_delay;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_we;
    logic [31:0] exp_res;
  } mem_vec_t;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [1:0]  exp_exc;
  } align_vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [4:0] waddr,
                               input logic wreg, input logic [31:0] wdata,
                               input logic [31:0] reg2);
    in_valid_i = 1'b1;
    mem_op_i   = op;
    waddr_i    = waddr;
    wreg_i     = wreg;
    wdata_i    = wdata;
    reg2_i     = reg2;
  endtask

  // One complete load or store: request fields checked on every REQ cycle,
  // grant after gnt_delay cycles, and for loads a stray rvalid alongside the
  // grant (must be ignored) followed by the real response one cycle later.
  task automatic runMemVector(input mem_vec_t v);
    applyStimulus(v.op, 5'd7, 1'b1, v.addr, v.reg2);
    nextCycle();
    in_valid_i = 1'b0;
    checkOutput({v.name, " req"}, 32'(dm_req_o), 32'd1);
    checkOutput({v.name, " we"}, 32'(dm_we_o), 32'(v.exp_we));
    checkOutput({v.name, " addr"}, dm_addr_o, v.exp_addr);
    checkOutput({v.name, " be"}, 32'(dm_be_o), 32'(v.exp_be));
    if (v.exp_we) checkOutput({v.name, " bus_wdata"}, dm_wdata_o, v.exp_wdata);
    checkOutput({v.name, " stall"}, 32'(stall_o), 32'd1);
    for (int i = 0; i < v.gnt_delay; i++) begin
      nextCycle();
      checkOutput({v.name, " req_hold"}, 32'(dm_req_o), 32'd1);
      checkOutput({v.name, " addr_hold"}, dm_addr_o, v.exp_addr);
      checkOutput({v.name, " be_hold"}, 32'(dm_be_o), 32'(v.exp_be));
      if (v.exp_we) checkOutput({v.name, " wdata_hold"}, dm_wdata_o, v.exp_wdata);
    end
    dm_gnt_i = 1'b1;
    if (!v.exp_we) begin
      dm_rvalid_i = 1'b1;
      dm_rdata_i  = 32'hBAD0BAD0;
    end
    nextCycle();
    dm_gnt_i    = 1'b0;
    dm_rvalid_i = 1'b0;
    checkOutput({v.name, " req_drop"}, 32'(dm_req_o), 32'd0);
    if (v.exp_we) begin
      checkOutput({v.name, " wb_valid"}, 32'(wb_valid_o), 32'd1);
      checkOutput({v.name, " wreg"}, 32'(wreg_o), 32'd0);
      checkOutput({v.name, " exc"}, 32'(exc_o), 32'(EXC_NONE));
      checkOutput({v.name, " ready"}, 32'(in_ready_o), 32'd1);
    end else begin
      checkOutput({v.name, " wait_no_wb"}, 32'(wb_valid_o), 32'd0);
      checkOutput({v.name, " wait_ready"}, 32'(in_ready_o), 32'd0);
      dm_rvalid_i = 1'b1;
      dm_rdata_i  = v.rdata;
      nextCycle();
      dm_rvalid_i = 1'b0;
      checkOutput({v.name, " wb_valid"}, 32'(wb_valid_o), 32'd1);
      checkOutput({v.name, " result"}, wdata_o, v.exp_res);
      checkOutput({v.name, " wreg"}, 32'(wreg_o), 32'd1);
      checkOutput({v.name, " waddr"}, 32'(waddr_o), 32'd7);
      checkOutput({v.name, " exc"}, 32'(exc_o), 32'(EXC_NONE));
      checkOutput({v.name, " ready"}, 32'(in_ready_o), 32'd1);
    end
    nextCycle();
    checkOutput({v.name, " wb_pulse_end"}, 32'(wb_valid_o), 32'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " req"}, 32'(dm_req_o), 32'd0);
    checkOutput({tag, " we"}, 32'(dm_we_o), 32'd0);
    checkOutput({tag, " addr"}, dm_addr_o, 32'd0);
    checkOutput({tag, " be"}, 32'(dm_be_o), 32'd0);
    checkOutput({tag, " bus_wdata"}, dm_wdata_o, 32'd0);
    checkOutput({tag, " wb_valid"}, 32'(wb_valid_o), 32'd0);
    checkOutput({tag, " waddr"}, 32'(waddr_o), 32'd0);
    checkOutput({tag, " wreg"}, 32'(wreg_o), 32'd0);
    checkOutput({tag, " wdata"}, wdata_o, 32'd0);
    checkOutput({tag, " exc"}, 32'(exc_o), 32'd0);
    checkOutput({tag, " ready"}, 32'(in_ready_o), 32'd1);
    checkOutput({tag, " stall"}, 32'(stall_o), 32'd0);
  endtask

  mem_vec_t   mem_vecs[10];
  align_vec_t align_vecs[5];

  initial begin
    mem_vecs[0] = '{"lb_sext",  MEM_OP_LB,  32'h00001003, 32'h0, 32'h80FFFFFF, 2,
                    32'h00001000, 4'b1000, 32'h0, 1'b0, 32'hFFFFFF80};
    mem_vecs[1] = '{"lbu_zext", MEM_OP_LBU, 32'h00001003, 32'h0, 32'h80FFFFFF, 2,
                    32'h00001000, 4'b1000, 32'h0, 1'b0, 32'h00000080};
    mem_vecs[2] = '{"lh_hi",    MEM_OP_LH,  32'h00000102, 32'h0, 32'h80017FFF, 1,
                    32'h00000100, 4'b1100, 32'h0, 1'b0, 32'hFFFF8001};
    mem_vecs[3] = '{"lhu_lo",   MEM_OP_LHU, 32'h00000100, 32'h0, 32'h1234F00D, 0,
                    32'h00000100, 4'b0011, 32'h0, 1'b0, 32'h0000F00D};
    mem_vecs[4] = '{"lw",       MEM_OP_LW,  32'h00000200, 32'h0, 32'hDEADBEEF, 1,
                    32'h00000200, 4'b1111, 32'h0, 1'b0, 32'hDEADBEEF};
    mem_vecs[5] = '{"lb_lane1", MEM_OP_LB,  32'h00000301, 32'h0, 32'h11227F44, 0,
                    32'h00000300, 4'b0010, 32'h0, 1'b0, 32'h0000007F};
    mem_vecs[6] = '{"sh_hi_gnt_at_limit", MEM_OP_SH, 32'h00002002, 32'h0000BEEF, 32'h0, 3,
                    32'h00002000, 4'b1100, 32'hBEEFBEEF, 1'b1, 32'h0};
    mem_vecs[7] = '{"sb_lane1", MEM_OP_SB,  32'h00003001, 32'h123456A5, 32'h0, 1,
                    32'h00003000, 4'b0010, 32'hA5A5A5A5, 1'b1, 32'h0};
    mem_vecs[8] = '{"sw",       MEM_OP_SW,  32'h00004000, 32'hCAFEF00D, 32'h0, 0,
                    32'h00004000, 4'b1111, 32'hCAFEF00D, 1'b1, 32'h0};
    mem_vecs[9] = '{"sh_lo",    MEM_OP_SH,  32'h00002000, 32'hFFFF1234, 32'h0, 2,
                    32'h00002000, 4'b0011, 32'h12341234, 1'b1, 32'h0};

    align_vecs[0] = '{"mis_lw",  MEM_OP_LW,  32'h00000006, EXC_ALIGN};
    align_vecs[1] = '{"mis_lh",  MEM_OP_LH,  32'h00000101, EXC_ALIGN};
    align_vecs[2] = '{"mis_sw",  MEM_OP_SW,  32'h00000002, EXC_ALIGN};
    align_vecs[3] = '{"mis_sh",  MEM_OP_SH,  32'h00000003, EXC_ALIGN};
    align_vecs[4] = '{"mis_lhu", MEM_OP_LHU, 32'h00000005, EXC_ALIGN};

    rst         = 1'b1;
    in_valid_i  = 1'b0;
    mem_op_i    = MEM_OP_NONE;
    waddr_i     = 5'd0;
    wreg_i      = 1'b0;
    wdata_i     = 32'd0;
    reg2_i      = 32'd0;
    dm_gnt_i    = 1'b0;
    dm_rvalid_i = 1'b0;
    dm_rdata_i  = 32'd0;

    // Reset state
    nextCycle();
    nextCycle();
    checkResetState("reset");
    rst = 1'b0;
    nextCycle();

    // Back-to-back pass-through, one result per cycle, never stalling
    applyStimulus(MEM_OP_NONE, 5'd3, 1'b1, 32'h12345678, 32'h0);
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkOutput("pass wb_valid", 32'(wb_valid_o), 32'd1);
      checkOutput("pass waddr", 32'(waddr_o), 32'd3);
      checkOutput("pass wreg", 32'(wreg_o), 32'd1);
      checkOutput("pass wdata", wdata_o, 32'h12345678);
      checkOutput("pass stall", 32'(stall_o), 32'd0);
      checkOutput("pass no_req", 32'(dm_req_o), 32'd0);
    end
    in_valid_i = 1'b0;
    nextCycle();
    checkOutput("pass pulse_end", 32'(wb_valid_o), 32'd0);
    checkOutput("pass wdata_hold", wdata_o, 32'h12345678);

    // Table of legal loads and stores
    for (int i = 0; i < 10; i++) runMemVector(mem_vecs[i]);

    // Misaligned accesses: no bus activity, immediate exception pulse
    for (int i = 0; i < 5; i++) begin
      applyStimulus(align_vecs[i].op, 5'd9, 1'b1, align_vecs[i].addr, 32'h0);
      nextCycle();
      in_valid_i = 1'b0;
      checkOutput({align_vecs[i].name, " no_req"}, 32'(dm_req_o), 32'd0);
      checkOutput({align_vecs[i].name, " wb_valid"}, 32'(wb_valid_o), 32'd1);
      checkOutput({align_vecs[i].name, " exc"}, 32'(exc_o), 32'(align_vecs[i].exp_exc));
      checkOutput({align_vecs[i].name, " wreg"}, 32'(wreg_o), 32'd0);
      checkOutput({align_vecs[i].name, " ready"}, 32'(in_ready_o), 32'd1);
    end
    nextCycle();
    checkOutput("mis pulse_end", 32'(wb_valid_o), 32'd0);
    checkOutput("mis exc_hold", 32'(exc_o), 32'(EXC_ALIGN));

    // Timeout in REQ: request held for exactly TIMEOUT cycles, then aborted
    applyStimulus(MEM_OP_LW, 5'd4, 1'b1, 32'h00000500, 32'h0);
    for (int i = 0; i < TIMEOUT; i++) begin
      nextCycle();
      in_valid_i = 1'b0;
      checkOutput("tmo req_held", 32'(dm_req_o), 32'd1);
      checkOutput("tmo no_wb", 32'(wb_valid_o), 32'd0);
    end
    nextCycle();
    checkOutput("tmo req_drop", 32'(dm_req_o), 32'd0);
    checkOutput("tmo wb_valid", 32'(wb_valid_o), 32'd1);
    checkOutput("tmo exc", 32'(exc_o), 32'(EXC_TIMEOUT));
    checkOutput("tmo wreg", 32'(wreg_o), 32'd0);
    checkOutput("tmo ready", 32'(in_ready_o), 32'd1);
    nextCycle();

    // Reset while waiting for load data, then a late rvalid must be ignored
    applyStimulus(MEM_OP_LW, 5'd5, 1'b1, 32'h00000600, 32'h0);
    nextCycle();
    in_valid_i = 1'b0;
    dm_gnt_i   = 1'b1;
    nextCycle();
    dm_gnt_i = 1'b0;
    checkOutput("rstwait in_wait", 32'(in_ready_o), 32'd0);
    rst = 1'b1;
    nextCycle();
    rst         = 1'b0;
    dm_rvalid_i = 1'b1;
    dm_rdata_i  = 32'h55555555;
    nextCycle();
    dm_rvalid_i = 1'b0;
    checkResetState("rstwait");
    runMemVector('{"lw_after_reset", MEM_OP_LW, 32'h00000700, 32'h0, 32'h0BADF00D, 1,
                   32'h00000700, 4'b1111, 32'h0, 1'b0, 32'h0BADF00D});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of the EX stage.
- Consumes EX results: destination register, write enable, ALU result (used as the effective address for loads and stores) and the store operand.
- Performs word, halfword and byte loads and stores over a request/grant/response data-memory bus, with a timeout.
- Delivers registered write-back data to the WB stage and stalls the upstream pipeline while an access is outstanding.

Parameters:
- TIMEOUT, 255, maximum cycles spent waiting in REQ or WAIT before the access is aborted (valid range 1..1023).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid_i  in  1  EX presents an instruction
- in_ready_o  out  1  block accepts an instruction this cycle (state==IDLE)
- mem_op_i  in  4  MEM_OP_* code
- waddr_i  in  5  destination register
- wreg_i  in  1  register write enable
- wdata_i  in  32  ALU result / effective address
- reg2_i  in  32  store data
- dm_req_o  out  1  memory request
- dm_we_o  out  1  1 = store
- dm_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dm_be_o  out  4  byte enables
- dm_wdata_o  out  32  lane-replicated store data
- dm_gnt_i  in  1  request accepted
- dm_rvalid_i  in  1  load data valid
- dm_rdata_i  in  32  load data
- wb_valid_o  out  1  one-cycle pulse, result valid
- waddr_o  out  5  to WB
- wreg_o  out  1  to WB
- wdata_o  out  32  to WB
- exc_o  out  2  00 none, 01 misaligned, 10 bus timeout
- stall_o  out  1  equals !in_ready_o

Behaviour:
- Reset: state=IDLE, dm_req_o=0, dm_we_o=0, dm_be_o=0, dm_addr_o=0, dm_wdata_o=0, wb_valid_o=0, waddr_o=0, wreg_o=0, wdata_o=0, exc_o=00, timeout counter=0.
- Reset mid-access abandons the access with no write-back.
- Accept rule: transfer when in_valid_i && in_ready_o. The operands are latched. in_ready_o=1 only in IDLE.
- MEM_OP_NONE: registered pass-through of waddr/wreg/wdata, wb_valid_o=1 next cycle. Stays IDLE, so back-to-back throughput is 1 per cycle.
- Alignment:
  - LW/SW need addr[1:0]==0.
  - LH/LHU/SH need addr[0]==0.
  - On violation: no bus access, wb_valid_o next cycle with wreg_o=0, exc_o=01.
- States:
  - IDLE: on a legal memory op, go to REQ. dm_req_o and the bus fields are registered, so they are driven from the first REQ cycle.
  - REQ: hold dm_req_o and all dm_* fields stable until dm_gnt_i.
    - Store granted: go to IDLE and pulse wb_valid_o the next cycle with wreg_o=0.
    - Load granted: go to WAIT and drop dm_req_o.
  - WAIT: on dm_rvalid_i, extract the lane and sign/zero-extend into wdata_o, set wb_valid_o=1, go to IDLE.
  - dm_rvalid_i in the same cycle as dm_gnt_i is ignored; rvalid is only sampled in WAIT.
- Byte enables:
  - SW: 1111.
  - SH: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - SB: 0001 shifted left by addr[1:0].
  - Store data replicated: byte in all four lanes; halfword as {h,h}.
- Load extract:
  - LB/LBU: byte = rdata[8*addr[1:0]+:8].
  - LH/LHU: half = rdata[16*addr[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Timeout:
  - Counter clears on entry to REQ or WAIT and increments each cycle there.
  - Reaching TIMEOUT with no gnt/rvalid: drop dm_req_o, go to IDLE, wb_valid_o with wreg_o=0, exc_o=10.
  - Grant or rvalid arriving in the same cycle the count hits TIMEOUT wins over the timeout.
- exc_o and wb fields hold their last value between pulses; only wb_valid_o is a pulse.

Decomposition:
- Shared defines file gets MEM_OP_NONE=0, LW=1, LH=2, LHU=3, LB=4, LBU=5, SW=6, SH=7, SB=8, and EXC_NONE/EXC_ALIGN/EXC_TIMEOUT.
- One sub-module, mem_align: combinational byte-enable generation, store-lane replication and load extract/extend, keyed on op and addr[1:0].

Test Plan:
- Pass-through: MEM_OP_NONE, waddr=3, wdata=0x12345678 on consecutive cycles -> wb_valid every cycle, waddr_o=3, wdata_o=0x12345678, stall_o never 1.
- LB sign-extend: addr=0x1003, gnt after 2 cycles, rdata=0x80FFFFFF one cycle later -> be n/a, wdata_o=0xFFFFFF80, wreg_o=1. Same access with LBU -> 0x00000080.
- SH: addr=0x2002, reg2=0x0000BEEF -> dm_addr=0x2000, dm_be=1100, dm_wdata=0xBEEFBEEF, fields stable until gnt, wb_valid with wreg_o=0.
- Misaligned: LW at 0x0006 -> no dm_req, wb_valid next cycle, exc_o=01, wreg_o=0.
- Timeout: TIMEOUT=4, no gnt -> dm_req low after 4 REQ cycles, exc_o=10, in_ready returns 1.
- Reset during WAIT, then rvalid -> no wb_valid, all outputs at reset values, next LW completes normally.
